// File: rtl/game_pkg.sv
// Shared constants for the game front-end: channel count, default debounce
// length and the debounce counter width helper.
package game_pkg;

    localparam int N_CH             = 18;
    localparam int DEBOUNCE_DEFAULT = 500000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Single-channel slide-switch conditioner: 2-FF synchroniser followed by a
// stability counter that only lets a level through after DEBOUNCE_CYCLES samples.
module switch_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_db
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the held level restarts the count.
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/mole_hit_detect.sv
// Switch front-end for scoring: debounce, toggle-edge detect and qualification
// against the lit mole mask. Define MISS_DETECT_EN to generate miss_pulse.
module mole_hit_detect
    import game_pkg::*;
#(
    parameter int N_CH            = game_pkg::N_CH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw_raw,
    input  logic [N_CH-1:0] mole_on,
    input  logic            game_active,
    input  logic            start_pulse,
    output logic [N_CH-1:0] hit_pulse,
    output logic            miss_pulse,
    output logic [N_CH-1:0] sw_db
);

    logic [N_CH-1:0] w_sw_db;
    logic [N_CH-1:0] w_edge;
    logic [N_CH-1:0] w_hit;
    logic            w_miss;

    logic [N_CH-1:0] r_sw_db_d;
    logic [N_CH-1:0] r_lockout;
    logic [N_CH-1:0] r_hit;
    logic            r_miss;
    logic            r_edge_arm;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .i_raw(sw_raw[g]),
            .o_db (w_sw_db[g])
        );
    end

    // Both switch directions are events: the switches are toggles, not buttons.
    assign w_edge = (w_sw_db ^ r_sw_db_d) & {N_CH{r_edge_arm}};
    assign w_hit  = w_edge & mole_on & {N_CH{game_active}} & ~r_lockout;

`ifdef MISS_DETECT_EN
    assign w_miss = game_active & (|(w_edge & ~mole_on));
`else
    assign w_miss = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_db_d  <= '0;
            r_lockout  <= '0;
            r_hit      <= '0;
            r_miss     <= 1'b0;
            r_edge_arm <= 1'b0;
        end else begin
            r_sw_db_d  <= w_sw_db;
            r_edge_arm <= 1'b1;
            if (start_pulse) begin
                r_hit     <= '0;
                r_miss    <= 1'b0;
                r_lockout <= '0;
            end else begin
                r_hit     <= w_hit;
                r_miss    <= w_miss;
                // An unlit mole clears its lockout, overriding a same-cycle set.
                r_lockout <= (r_lockout | w_hit) & mole_on;
            end
        end
    end

    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;
    assign sw_db      = w_sw_db;

endmodule

// File: tb/tb_mole_hit_detect.sv
// Directed bench for mole_hit_detect with DEBOUNCE_CYCLES=4; inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_mole_hit_detect;

    localparam int NC = 18;
    localparam int D  = 4;

`ifdef MISS_DETECT_EN
    localparam logic MISS_EXP = 1'b1;
`else
    localparam logic MISS_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NC-1:0] sw_raw = '0;
    logic [NC-1:0] mole_on = '0;
    logic          game_active = 1'b0;
    logic          start_pulse = 1'b0;
    logic [NC-1:0] hit_pulse;
    logic          miss_pulse;
    logic [NC-1:0] sw_db;

    int n_vec = 0;
    int n_err = 0;

    mole_hit_detect #(
        .N_CH(NC),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .mole_on    (mole_on),
        .game_active(game_active),
        .start_pulse(start_pulse),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .sw_db      (sw_db)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (hit_pulse !== '0) begin
            n_err++;
            $display("FAIL reset_hit got=%h exp=%h", hit_pulse, 18'h0);
        end
        n_vec++;
        if (miss_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_miss got=%b exp=0", miss_pulse);
        end
        n_vec++;
        if (sw_db !== '0) begin
            n_err++;
            $display("FAIL reset_swdb got=%h exp=%h", sw_db, 18'h0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_hit();
        logic [NC-1:0] exp_hit;
        game_active = 1'b1;
        mole_on     = 18'h00020;
        sw_raw[5]   = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_hit = (k == 3 + D) ? 18'h00020 : 18'h0;
            n_vec++;
            if (hit_pulse !== exp_hit) begin
                n_err++;
                $display("FAIL single_hit t%0d got=%h exp=%h", k, hit_pulse, exp_hit);
            end
            n_vec++;
            if (miss_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL single_miss t%0d got=%b exp=0", k, miss_pulse);
            end
            if (k == 1 + D || k == 2 + D) begin
                n_vec++;
                if (sw_db[5] !== (k == 2 + D)) begin
                    n_err++;
                    $display("FAIL single_swdb t%0d got=%b exp=%b", k, sw_db[5], k == 2 + D);
                end
            end
        end
        mole_on = '0;
        tick();
    endtask

    task automatic test_glitch();
        mole_on   = 18'h00008;
        sw_raw[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_vec++;
            if (sw_db[3] !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_swdb t%0d got=%b exp=0", k, sw_db[3]);
            end
            n_vec++;
            if (hit_pulse !== '0) begin
                n_err++;
                $display("FAIL glitch_hit t%0d got=%h exp=%h", k, hit_pulse, 18'h0);
            end
            if (k == 3) sw_raw[3] = 1'b0;
        end
        mole_on = '0;
    endtask

    task automatic test_lockout();
        logic [NC-1:0] exp_hit;
        mole_on   = 18'h00001;
        sw_raw[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_hit = (k == 3 + D) ? 18'h00001 : 18'h0;
            n_vec++;
            if (hit_pulse !== exp_hit) begin
                n_err++;
                $display("FAIL lock_first t%0d got=%h exp=%h", k, hit_pulse, exp_hit);
            end
        end
        sw_raw[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++;
            if (hit_pulse !== '0) begin
                n_err++;
                $display("FAIL lock_block t%0d got=%h exp=%h", k, hit_pulse, 18'h0);
            end
        end
        mole_on = '0;
        tick();
        mole_on   = 18'h00001;
        sw_raw[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_hit = (k == 3 + D) ? 18'h00001 : 18'h0;
            n_vec++;
            if (hit_pulse !== exp_hit) begin
                n_err++;
                $display("FAIL lock_rearm t%0d got=%h exp=%h", k, hit_pulse, exp_hit);
            end
        end
    endtask

    task automatic test_miss_multi();
        logic [NC-1:0] exp_hit;
        logic          exp_miss;
        mole_on = '0;
        tick();
        mole_on   = 18'h00001;
        sw_raw[0] = 1'b0;
        sw_raw[9] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_hit  = (k == 3 + D) ? 18'h00001 : 18'h0;
            exp_miss = (k == 3 + D) ? MISS_EXP : 1'b0;
            n_vec++;
            if (hit_pulse !== exp_hit) begin
                n_err++;
                $display("FAIL multi_hit t%0d got=%h exp=%h", k, hit_pulse, exp_hit);
            end
            n_vec++;
            if (miss_pulse !== exp_miss) begin
                n_err++;
                $display("FAIL multi_miss t%0d got=%b exp=%b", k, miss_pulse, exp_miss);
            end
        end
        mole_on = '0;
        tick();
    endtask

    task automatic test_idle_start();
        logic [NC-1:0] exp_hit;
        game_active = 1'b1;
        mole_on     = 18'h00004;
        sw_raw[2]   = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_hit = (k == 3 + D) ? 18'h00004 : 18'h0;
            n_vec++;
            if (hit_pulse !== exp_hit) begin
                n_err++;
                $display("FAIL start_arm t%0d got=%h exp=%h", k, hit_pulse, exp_hit);
            end
        end
        // Channel 2 is now locked out with its mole still lit.
        game_active = 1'b0;
        sw_raw[2]   = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if (hit_pulse !== '0 || miss_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL idle t%0d got=%h/%b exp=%h/0", k, hit_pulse, miss_pulse, 18'h0);
            end
        end
        game_active = 1'b1;
        sw_raw[2]   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if (hit_pulse !== '0 || miss_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL start_discard t%0d got=%h/%b exp=%h/0", k, hit_pulse, miss_pulse, 18'h0);
            end
            if (k == 2 + D) start_pulse = 1'b1;
            if (k == 3 + D) start_pulse = 1'b0;
        end
        sw_raw[2] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_hit = (k == 3 + D) ? 18'h00004 : 18'h0;
            n_vec++;
            if (hit_pulse !== exp_hit) begin
                n_err++;
                $display("FAIL start_unlock t%0d got=%h exp=%h", k, hit_pulse, exp_hit);
            end
        end
        mole_on = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        game_active = 1'b0;
        mole_on     = 18'h00080;
        sw_raw[7]   = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (sw_db !== '0 || hit_pulse !== '0 || miss_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_clear got=%h/%h/%b exp=0/0/0", sw_db, hit_pulse, miss_pulse);
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_vec++;
            if (hit_pulse !== '0 || miss_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_pulse t%0d got=%h/%b exp=%h/0", k, hit_pulse, miss_pulse, 18'h0);
            end
            if (k == 1 + D) begin
                n_vec++;
                if (sw_db !== '0) begin
                    n_err++;
                    $display("FAIL rstmid_early t%0d got=%h exp=%h", k, sw_db, 18'h0);
                end
            end
            if (k == 2 + D) begin
                n_vec++;
                if (sw_db !== 18'h002A0) begin
                    n_err++;
                    $display("FAIL rstmid_conv t%0d got=%h exp=%h", k, sw_db, 18'h002A0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_glitch();
        test_lockout();
        test_miss_multi();
        test_idle_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
